// File: rtl/calculator_param.sv
// ============================================================================
// Module   : calculator_param
// Purpose  : Parameterised multi-cycle calculator with shift-add multiply and
//            restoring divide, controlled by a five-state FSM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module calculator_param #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         Go,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic [2:0]   f,
    output logic         Done,
    output logic         Busy,
    output logic         Err,
    output logic [W-1:0] Out_H,
    output logic [W-1:0] Out_L
);

    localparam int            CW     = $clog2(W + 1);
    localparam logic [CW-1:0] c_TERM = CW'(W - 1);

    localparam logic [2:0] c_OP_ADD = 3'b000;
    localparam logic [2:0] c_OP_SUB = 3'b001;
    localparam logic [2:0] c_OP_AND = 3'b010;
    localparam logic [2:0] c_OP_XOR = 3'b011;
    localparam logic [2:0] c_OP_MUL = 3'b100;
    localparam logic [2:0] c_OP_DIV = 3'b101;
    localparam logic [2:0] c_OP_MAX = 3'b110;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_EXEC = 3'd1,
        S_MUL  = 3'd2,
        S_DIV  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic [2:0]     r_f;
    logic [CW-1:0]  r_cnt;
    logic [W-1:0]   r_hi;
    logic [W-1:0]   r_lo;
    logic [W-1:0]   r_out_h;
    logic [W-1:0]   r_out_l;
    logic           r_err;

    // Single-cycle result
    logic [W:0]     w_add;
    logic [W-1:0]   w_res_h;
    logic [W-1:0]   w_res_l;
    logic           w_res_err;

    // Iterative step: {r_hi,r_lo} is product (mul) or {remainder,quotient} (div)
    logic [W:0]     w_mul_sum;
    logic [W-1:0]   w_mul_hi;
    logic [W-1:0]   w_mul_lo;
    logic [W:0]     w_div_shift;
    logic           w_div_fit;
    logic [W-1:0]   w_div_hi;
    logic [W-1:0]   w_div_lo;

    assign w_add       = {1'b0, r_a} + {1'b0, r_b};

    assign w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
    assign w_mul_hi    = w_mul_sum[W:1];
    assign w_mul_lo    = {w_mul_sum[0], r_lo[W-1:1]};

    // The restored remainder is always below r_b, so W-bit subtraction suffices
    assign w_div_shift = {r_hi, r_lo[W-1]};
    assign w_div_fit   = (w_div_shift >= {1'b0, r_b});
    assign w_div_hi    = w_div_fit ? (w_div_shift[W-1:0] - r_b) : w_div_shift[W-1:0];
    assign w_div_lo    = {r_lo[W-2:0], w_div_fit};

    always_comb begin
        w_res_h   = '0;
        w_res_l   = '0;
        w_res_err = 1'b0;
        case (r_f)
            c_OP_ADD: begin
                w_res_l = w_add[W-1:0];
                w_res_h = {{(W-1){1'b0}}, w_add[W]};
            end
            c_OP_SUB: begin
                w_res_l = r_a - r_b;
                w_res_h = {W{(r_a < r_b)}};
            end
            c_OP_AND: w_res_l = r_a & r_b;
            c_OP_XOR: w_res_l = r_a ^ r_b;
            c_OP_MAX: w_res_l = (r_a > r_b) ? r_a : r_b;
            c_OP_DIV: begin
                w_res_err = 1'b1;
                w_res_l   = '1;
                w_res_h   = r_a;
            end
            c_OP_MUL: w_res_l = '0;
            default:  w_res_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (Go) w_next = S_EXEC;
            S_EXEC: begin
                if (r_f == c_OP_MUL)                     w_next = S_MUL;
                else if (r_f == c_OP_DIV && r_b != '0)   w_next = S_DIV;
                else                                     w_next = S_DONE;
            end
            S_MUL:  if (r_cnt == c_TERM) w_next = S_DONE;
            S_DIV:  if (r_cnt == c_TERM) w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_f     <= '0;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_out_h <= '0;
            r_out_l <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (Go) begin
                    r_a <= x;
                    r_b <= y;
                    r_f <= f;
                end
                S_EXEC: begin
                    r_cnt <= '0;
                    r_hi  <= '0;
                    r_lo  <= (r_f == c_OP_MUL) ? r_b : r_a;
                    if (w_next == S_DONE) begin
                        r_out_h <= w_res_h;
                        r_out_l <= w_res_l;
                        r_err   <= w_res_err;
                    end
                end
                S_MUL: begin
                    r_hi  <= w_mul_hi;
                    r_lo  <= w_mul_lo;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == c_TERM) begin
                        r_out_h <= w_mul_hi;
                        r_out_l <= w_mul_lo;
                        r_err   <= 1'b0;
                    end
                end
                S_DIV: begin
                    r_hi  <= w_div_hi;
                    r_lo  <= w_div_lo;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == c_TERM) begin
                        r_out_h <= w_div_hi;
                        r_out_l <= w_div_lo;
                        r_err   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Done  = (r_state == S_DONE);
    assign Busy  = (r_state != S_IDLE);
    assign Err   = r_err;
    assign Out_H = r_out_h;
    assign Out_L = r_out_l;

endmodule

`default_nettype wire

// File: tb/tb_calculator_param.sv
// ============================================================================
// Module   : tb_calculator_param
// Purpose  : Self-checking bench for calculator_param at W=4 and W=8.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_calculator_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] go  = 2'b00;
    logic [7:0] xa [2];
    logic [7:0] ya [2];
    logic [2:0] fa [2];

    logic       dn0, bs0, er0, dn1, bs1, er1;
    logic [3:0] oh0, ol0;
    logic [7:0] oh1, ol1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    calculator_param #(.W(4)) u_dut4 (
        .clk(clk), .rst(rst), .Go(go[0]), .x(xa[0][3:0]), .y(ya[0][3:0]), .f(fa[0]),
        .Done(dn0), .Busy(bs0), .Err(er0), .Out_H(oh0), .Out_L(ol0)
    );

    calculator_param #(.W(8)) u_dut8 (
        .clk(clk), .rst(rst), .Go(go[1]), .x(xa[1]), .y(ya[1]), .f(fa[1]),
        .Done(dn1), .Busy(bs1), .Err(er1), .Out_H(oh1), .Out_L(ol1)
    );

    // Observation vector: {Done, Busy, Err, Out_H[7:0], Out_L[7:0]}
    function automatic logic [18:0] obs(int k);
        if (k == 0) return {dn0, bs0, er0, 4'h0, oh0, 4'h0, ol0};
        return {dn1, bs1, er1, oh1, ol1};
    endfunction

    // Result of an operation: {Err, Out_H, Out_L}
    function automatic logic [16:0] calc(int w, int a_in, int b_in, int op);
        int  mask = (1 << w) - 1;
        int  a    = a_in & mask;
        int  b    = b_in & mask;
        int  hi   = 0;
        int  lo   = 0;
        bit  err  = 1'b0;
        int  p;
        case (op)
            0: begin p = a + b; lo = p & mask; hi = p >> w; end
            1: begin lo = (a - b) & mask; hi = (a < b) ? mask : 0; end
            2: lo = a & b;
            3: lo = a ^ b;
            4: begin p = a * b; lo = p & mask; hi = p >> w; end
            5: begin
                if (b == 0) begin err = 1'b1; lo = mask; hi = a; end
                else begin lo = a / b; hi = a % b; end
            end
            6: lo = (a > b) ? a : b;
            default: err = 1'b1;
        endcase
        return {err, 8'(hi), 8'(lo)};
    endfunction

    function automatic int latency(int w, int b_in, int op);
        int b = b_in & ((1 << w) - 1);
        return (op == 4 || (op == 5 && b != 0)) ? w + 2 : 2;
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Transaction-level model: idle / counting down to Done / Done for one cycle
    logic        m_idle [2];
    logic        m_done [2];
    int          m_left [2];
    logic [16:0] m_pend [2];
    logic [16:0] m_res  [2];
    logic        m_valid = 1'b0;

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_idle[k] <= 1'b1;
                m_done[k] <= 1'b0;
                m_left[k] <= 0;
                m_res[k]  <= '0;
            end else if (m_done[k]) begin
                m_done[k] <= 1'b0;
                m_idle[k] <= 1'b1;
            end else if (m_idle[k]) begin
                if (go[k]) begin
                    m_idle[k] <= 1'b0;
                    m_pend[k] <= calc(k == 0 ? 4 : 8, int'(xa[k]), int'(ya[k]), int'(fa[k]));
                    m_left[k] <= latency(k == 0 ? 4 : 8, int'(ya[k]), int'(fa[k])) - 1;
                end
            end else if (m_left[k] == 1) begin
                m_done[k] <= 1'b1;
                m_res[k]  <= m_pend[k];
                m_left[k] <= 0;
            end else begin
                m_left[k] <= m_left[k] - 1;
            end
        end
        if (rst) m_valid <= 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            for (int k = 0; k < 2; k++)
                check(k == 0 ? "cycle_w4" : "cycle_w8", 32'(obs(k)),
                      32'({m_done[k], ~m_idle[k], m_res[k]}));
        end
    end

    task automatic run_op(input int k, input int a, input int b, input int op,
                          input bit toggle, output int lat, output logic [16:0] res);
        logic [18:0] t;
        @(negedge clk);
        xa[k] = 8'(a); ya[k] = 8'(b); fa[k] = 3'(op); go[k] = 1'b1;
        lat = 0;
        res = '0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            go[k] = 1'b0;
            if (toggle) begin
                xa[k] = ~xa[k]; ya[k] = ~ya[k]; fa[k] = ~fa[k];
            end
            t = obs(k);
            if (t[18]) begin
                lat = n;
                res = t[16:0];
                break;
            end
        end
    endtask

    task automatic directed(string name, int k, int a, int b, int op, bit tog,
                            int exp_lat, logic [16:0] exp_res);
        int          lat;
        logic [16:0] res;
        run_op(k, a, b, op, tog, lat, res);
        check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        check({name, "_result"}, 32'(res), 32'(exp_res));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [18:0] t;
        int          pulses;
        int          wide;
        logic        prev;
        for (int k = 0; k < 2; k++) begin
            xa[k] = '0; ya[k] = '0; fa[k] = '0;
        end
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("reset_w4", 32'(obs(0)), 32'h0);
        check("reset_w8", 32'(obs(1)), 32'h0);
        rst = 1'b0;

        // Hand-computed expectations; result packed as {Err, Out_H, Out_L}
        directed("add_9_8",    0,  9, 8, 0, 1'b0,  2, {1'b0, 8'h01, 8'h01});
        directed("sub_3_5",    0,  3, 5, 1, 1'b0,  2, {1'b0, 8'h0F, 8'h0E});
        directed("max_3_5",    0,  3, 5, 6, 1'b0,  2, {1'b0, 8'h00, 8'h05});
        directed("mul_15_15",  0, 15, 15, 4, 1'b1, 6, {1'b0, 8'h0E, 8'h01});
        directed("div_13_4",   0, 13, 4, 5, 1'b0,  6, {1'b0, 8'h01, 8'h03});
        directed("div_7_0",    0,  7, 0, 5, 1'b0,  2, {1'b1, 8'h07, 8'h0F});
        directed("reserved",   0,  6, 9, 7, 1'b0,  2, {1'b1, 8'h00, 8'h00});
        directed("w8_div",     1, 200, 7, 5, 1'b0, 10, {1'b0, 8'd4, 8'd28});
        directed("w8_mul",     1, 255, 255, 4, 1'b1, 10, {1'b0, 8'hFE, 8'h01});

        // Multiply interrupted by reset in its third iteration
        directed("mul_setup",  0, 15, 15, 4, 1'b0, 6, {1'b0, 8'h0E, 8'h01});
        @(negedge clk);
        xa[0] = 8'd15; ya[0] = 8'd15; fa[0] = 3'd4; go[0] = 1'b1;
        @(negedge clk);
        go[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_reset", 32'(obs(0)), 32'h0);
        rst = 1'b0;
        directed("after_reset", 0, 9, 8, 0, 1'b0, 2, {1'b0, 8'h01, 8'h01});

        // Go held high: accepted only from IDLE, one Done every three edges
        @(negedge clk);
        xa[0] = 8'd9; ya[0] = 8'd8; fa[0] = 3'd0; go[0] = 1'b1;
        pulses = 0;
        wide   = 0;
        prev   = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            t = obs(0);
            if (t[18]) pulses++;
            if (t[18] && prev) wide++;
            prev = t[18];
        end
        go[0] = 1'b0;
        check("go_hold_pulses", 32'(pulses), 32'd10);
        check("go_hold_width", 32'(wide), 32'd0);

        // Randomised traffic against the model
        for (int n = 0; n < 2500; n++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 149) == 0);
            for (int k = 0; k < 2; k++) begin
                go[k] = ($urandom_range(0, 2) != 0);
                xa[k] = 8'($urandom);
                ya[k] = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
                fa[k] = 3'($urandom_range(0, 7));
            end
        end
        @(negedge clk);
        rst = 1'b0;
        go  = 2'b00;
        repeat (20) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/calculator_param.md
CALCULATOR_PARAM -- requirements
Module: calculator_param

Interface
REQ-001 Parameter: W, default 4, operand width in bits; legal range 2..16.
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: rst  input  1  reset; synchronous and active-high.
REQ-004 Port: Go  input  1  start request; sampled only in IDLE.
REQ-005 Port: x  input  W  operand A; captured on the accepting edge.
REQ-006 Port: y  input  W  operand B; captured on the accepting edge.
REQ-007 Port: f  input  3  operation code; captured on the accepting edge.
REQ-008 Port: Done  output  1  result valid; single-cycle pulse.
REQ-009 Port: Busy  output  1  high whenever the FSM is not in IDLE.
REQ-010 Port: Err  output  1  error flag; valid with Done and held with the result.
REQ-011 Port: Out_H  output  W  upper result word, registered.
REQ-012 Port: Out_L  output  W  lower result word, registered.

Function
REQ-013 The FSM SHALL have the states IDLE, EXEC, MUL, DIV and DONE.
REQ-014 In IDLE with Go=1, the clock edge SHALL capture x, y and f and go to EXEC; Go=1 in any other state SHALL be ignored.
REQ-015 EXEC SHALL do the following:
- single-cycle codes: register the result and go to DONE;
- f=100: initialise the iterative multiplier and go to MUL;
- f=101 with y!=0: initialise the iterative divider and go to DIV.
REQ-016 The f=000 (add) result SHALL be Out_L=(x+y) mod 2^W and Out_H={W-1 zeros, carry}.
REQ-017 The f=001 (sub) result SHALL be Out_L=(x-y) mod 2^W and Out_H=all ones if x<y (unsigned), else all zeros.
REQ-018 The f=010 (and) result SHALL be Out_L=x&y and Out_H=0.
- f=011 (xor): Out_L=x^y, Out_H=0.
- f=110 (max): Out_L=unsigned max(x,y), Out_H=0.
REQ-019 The f=100 (mul) result SHALL be {Out_H,Out_L}=x*y as an unsigned 2W-bit product, computed shift-add in exactly W MUL cycles.
REQ-020 The f=101 (div) result SHALL be Out_L=quotient and Out_H=remainder (unsigned restoring division), computed in exactly W DIV cycles.
REQ-021 For f=101 with y=0, EXEC SHALL go to DONE with Err=1, Out_L=all ones and Out_H=x.
REQ-022 For f=111 (reserved), EXEC SHALL go to DONE with Err=1, Out_H=0 and Out_L=0.
REQ-023 Err SHALL be 0 for every other operation.
REQ-024 Latency, counted from the Go-accepting edge to the edge after which Done=1, SHALL be 2 edges for single-cycle, error and reserved codes, and W+2 edges for mul and div (W=4: 6 edges).
REQ-025 DONE SHALL last exactly one cycle with Done=1 and then return unconditionally to IDLE.
REQ-026 A new Go is accepted no earlier than the edge after DONE, so back-to-back operations have a minimum spacing of latency+1 edges.
REQ-027 Out_H, Out_L and Err SHALL update only on entry to DONE and SHALL hold their values until the next entry to DONE.
REQ-028 Intermediate multiply/divide registers SHALL NOT be visible on Out_H or Out_L.
REQ-029 Changes on x, y or f after the accepting edge SHALL NOT affect the operation in progress.
REQ-030 Busy SHALL be 1 in EXEC, MUL, DIV and DONE, and 0 in IDLE.
REQ-031 The MUL/DIV iteration counter SHALL be ceil(log2(W+1)) bits wide, and its terminal count SHALL be W-1.

Reset
REQ-032 With rst=1 at a rising edge, the next state SHALL be IDLE with Done=0, Busy=0, Err=0, Out_H=0, Out_L=0 and the counter and operand registers cleared, regardless of current state.
REQ-033 rst SHALL take priority over Go on the same edge.
REQ-034 A reset during MUL or DIV SHALL abort the operation with no Done pulse.
REQ-035 After rst deasserts, the first edge with Go=1 SHALL start a new operation normally.

Verification (W=4 unless stated)
REQ-036 The bench SHALL cover add: x=9, y=8, f=000 -> Done after 2 edges, Out_H=0001, Out_L=0001, Err=0.
REQ-037 The bench SHALL cover sub: x=3, y=5, f=001 -> Out_H=1111, Out_L=1110.
- It SHALL also cover max: x=3, y=5, f=110 -> Out_L=0101, Out_H=0000.
REQ-038 The bench SHALL cover mul: x=15, y=15, f=100 -> Done after exactly 6 edges, Out_H=1110, Out_L=0001.
- It SHALL toggle x during MUL and check the result is unchanged.
REQ-039 The bench SHALL cover div and errors:
- x=13, y=4, f=101 -> after 6 edges Out_L=0011, Out_H=0001;
- x=7, y=0, f=101 -> after 2 edges Err=1, Out_L=1111, Out_H=0111;
- f=111 -> Err=1, outputs 0.
REQ-040 The bench SHALL cover reset and Go handling:
- assert rst in the 3rd MUL cycle -> no Done, all outputs 0 on the next edge;
- hold Go high continuously -> operations restart only from IDLE, with Done pulses one cycle wide.
REQ-041 The bench SHALL cover W=8: x=200, y=7, f=101 -> Out_L=28, Out_H=4 after 10 edges; x=255, y=255, f=100 -> {Out_H,Out_L}=65025.
